// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: forwarding select type and shadow-slot metadata shared by the hazard unit
package fwd;
    typedef enum logic {no_fwd = 1'b0, use_fwd = 1'b1} fwd_sel_t;
endpackage

package rv32i_types;
    typedef struct packed {
        logic use1;
        logic use2;
        logic regwrite;
        logic is_load;
    } hz_slot_t;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/fwd_hazard_unit_slot_reg.sv
// hz_slot_reg: one shadow pipeline slot; hold freezes it, bubble loads an invalid entry
module hz_slot_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (!hold) begin
            q_valid <= d_valid & ~bubble;
            q       <= d;
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage forwarding selects and load-use stall from a shadow EX/MEM/WB pipeline
module fwd_hazard_unit
    import fwd::*;
    import rv32i_types::*;
#(
    parameter int NREG_BITS = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NREG_BITS-1:0] id_rs1,
    input  logic [NREG_BITS-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 mem_stall,
    input  logic                 flush,
    output fwd_sel_t             alumux1_fwd_sel_exmem,
    output fwd_sel_t             alumux2_fwd_sel_exmem,
    output fwd_sel_t             alumux1_fwd_sel_memwb,
    output fwd_sel_t             alumux2_fwd_sel_memwb,
    output logic                 load_use_stall,
    output logic [CNT_W-1:0]     load_use_count
);
    localparam int EXW  = 4 + 3 * NREG_BITS;
    localparam int MEMW = NREG_BITS + 2;
    localparam int WBW  = NREG_BITS + 1;
    localparam logic [NREG_BITS-1:0] RZ = NREG_BITS'(REG_ZERO);

    hz_slot_t             id_f, ex_f;
    logic [EXW-1:0]       ex_q;
    logic [MEMW-1:0]      mem_q;
    logic [WBW-1:0]       wb_q;
    logic                 ex_valid, mem_valid, wb_valid;
    logic [NREG_BITS-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic                 mem_rw, mem_ld, wb_rw;
    logic                 ex_prod, mem_prod, wb_prod, raw;

    assign id_f = '{use1: id_uses_rs1, use2: id_uses_rs2, regwrite: id_regwrite, is_load: id_is_load};
    assign {ex_f, ex_rs1, ex_rs2, ex_rd} = ex_q;
    assign {mem_rd, mem_rw, mem_ld}      = mem_q;
    assign {wb_rd, wb_rw}                = wb_q;

    hz_slot_reg #(.W(EXW)) u_ex (
        .clk(clk), .rst_n(rst_n), .hold(mem_stall), .bubble(flush | load_use_stall),
        .d_valid(id_valid), .d({id_f, id_rs1, id_rs2, id_rd}), .q_valid(ex_valid), .q(ex_q)
    );
    hz_slot_reg #(.W(MEMW)) u_mem (
        .clk(clk), .rst_n(rst_n), .hold(mem_stall), .bubble(1'b0),
        .d_valid(ex_valid), .d({ex_rd, ex_f.regwrite, ex_f.is_load}), .q_valid(mem_valid), .q(mem_q)
    );
    hz_slot_reg #(.W(WBW)) u_wb (
        .clk(clk), .rst_n(rst_n), .hold(mem_stall), .bubble(1'b0),
        .d_valid(mem_valid), .d({mem_rd, mem_rw}), .q_valid(wb_valid), .q(wb_q)
    );

    // exmem excludes loads: their data is not ready until WB, the stall covers that gap
    always_comb begin
        ex_prod  = ex_valid & ex_f.regwrite & (ex_rd != RZ);
        mem_prod = mem_valid & mem_rw & (mem_rd != RZ);
        wb_prod  = wb_valid & wb_rw & (wb_rd != RZ);
        alumux1_fwd_sel_exmem = (ex_valid & ex_f.use1 & mem_prod & ~mem_ld & (ex_rs1 == mem_rd)) ? use_fwd : no_fwd;
        alumux2_fwd_sel_exmem = (ex_valid & ex_f.use2 & mem_prod & ~mem_ld & (ex_rs2 == mem_rd)) ? use_fwd : no_fwd;
        alumux1_fwd_sel_memwb = (ex_valid & ex_f.use1 & wb_prod & (ex_rs1 == wb_rd)) ? use_fwd : no_fwd;
        alumux2_fwd_sel_memwb = (ex_valid & ex_f.use2 & wb_prod & (ex_rs2 == wb_rd)) ? use_fwd : no_fwd;
        raw = id_valid & ex_f.is_load & ex_prod &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        load_use_stall = raw & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_use_count <= '0;
        else if (load_use_stall & ~mem_stall & ~&load_use_count)
            load_use_count <= load_use_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench against an instruction-level pipeline model
module tb_fwd_hazard_unit;
    import fwd::*;
    localparam int NB = 5;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_regwrite = 0, id_is_load = 0;
    logic [NB-1:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic mem_stall = 0, flush = 0;
    fwd_sel_t a1x, a2x, a1w, a2w;
    logic lus;
    logic [CW-1:0] luc;

    fwd_hazard_unit #(.NREG_BITS(NB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .mem_stall(mem_stall), .flush(flush),
        .alumux1_fwd_sel_exmem(a1x), .alumux2_fwd_sel_exmem(a2x),
        .alumux1_fwd_sel_memwb(a1w), .alumux2_fwd_sel_memwb(a2w),
        .load_use_stall(lus), .load_use_count(luc)
    );

    always #5 clk = ~clk;

    typedef struct {bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit ld;} ins_t;
    typedef struct {bit x1; bit x2; bit w1; bit w2; bit st; int cnt;} exp_t;

    ins_t pipe[3];
    exp_t sbq[$];
    int cnt_m = 0, total = 0, passed = 0;

    function automatic ins_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit ld);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.rd = rd; i.rw = rw; i.ld = ld;
        return i;
    endfunction

    function automatic bit prod(ins_t i);
        return i.v && i.rw && i.rd != 0;
    endfunction

    task automatic chk(string n, int a, int x);
        total++;
        if (a == x) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, x, $time);
    endtask

    // one cycle: apply inputs, predict outputs from model state, then advance the model across the edge
    task automatic drive(input ins_t i, input bit ms, input bit fl, input bit rn, output bit st);
        exp_t e;
        ins_t ex, mem, wb, bub;
        bit raw;
        @(posedge clk);
        #2;
        rst_n = rn; id_valid = i.v; id_rs1 = NB'(i.rs1); id_rs2 = NB'(i.rs2);
        id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_rd = NB'(i.rd);
        id_regwrite = i.rw; id_is_load = i.ld; mem_stall = ms; flush = fl;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (!rn) begin
            pipe[0] = bub; pipe[1] = bub; pipe[2] = bub; cnt_m = 0;
        end
        ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
        raw = i.v && ex.ld && prod(ex) && ((i.u1 && i.rs1 == ex.rd) || (i.u2 && i.rs2 == ex.rd));
        e.st  = raw && !fl;
        e.x1  = ex.v && ex.u1 && prod(mem) && !mem.ld && ex.rs1 == mem.rd;
        e.x2  = ex.v && ex.u2 && prod(mem) && !mem.ld && ex.rs2 == mem.rd;
        e.w1  = ex.v && ex.u1 && prod(wb) && ex.rs1 == wb.rd;
        e.w2  = ex.v && ex.u2 && prod(wb) && ex.rs2 == wb.rd;
        e.cnt = cnt_m;
        sbq.push_back(e);
        st = e.st;
        if (rn && !ms) begin
            pipe[2] = mem; pipe[1] = ex;
            pipe[0] = (fl || e.st) ? bub : i;
            if (e.st && cnt_m < CMAX) cnt_m++;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("exmem1", int'(a1x == use_fwd), int'(e.x1));
                chk("exmem2", int'(a2x == use_fwd), int'(e.x2));
                chk("memwb1", int'(a1w == use_fwd), int'(e.w1));
                chk("memwb2", int'(a2w == use_fwd), int'(e.w2));
                chk("stall", int'(lus), int'(e.st));
                chk("count", int'(luc), e.cnt);
            end
        end
    end

    initial begin
        ins_t nop, cur;
        bit st, ms, fl, rn, hold_id;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        pipe[0] = nop; pipe[1] = nop; pipe[2] = nop;
        drive(nop, 0, 0, 0, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, 1, st);
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0), 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 5, 2, 1, 1, 7, 1, 0), 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 1, st);
        drive(mk(1, 8, 1, 1, 1, 9, 1, 0), 0, 0, 1, st);
        drive(mk(1, 8, 1, 1, 1, 9, 1, 0), 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 1, 0, 1, 0, 0, 1, 0), 0, 0, 1, st);
        drive(mk(1, 0, 0, 1, 1, 3, 1, 0), 0, 0, 1, st);
        drive(mk(1, 1, 0, 1, 0, 0, 1, 1), 0, 0, 1, st);
        drive(mk(1, 0, 0, 1, 1, 3, 1, 0), 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 1, st);
        drive(mk(1, 8, 1, 1, 1, 9, 1, 0), 0, 1, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(nop, 0, 0, 1, st);
        drive(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 1, st);
        cur = mk(1, 1, 8, 1, 1, 9, 1, 0);
        for (int k = 0; k < 3; k++) drive(cur, 1, 0, 1, st);
        drive(cur, 0, 0, 1, st);
        drive(cur, 0, 0, 1, st);
        drive(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 1, st);
        drive(cur, 1, 0, 1, st);
        drive(cur, 1, 0, 0, st);
        drive(nop, 0, 0, 1, st);
        hold_id = 0;
        cur = nop;
        for (int k = 0; k < 600; k++) begin
            if (!hold_id)
                cur = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                         $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            ms = $urandom_range(0, 6) == 0;
            fl = $urandom_range(0, 9) == 0;
            rn = $urandom_range(0, 199) != 0;
            drive(cur, ms, fl, rn, st);
            hold_id = (st || ms) && !fl && rn;
        end
        drive(nop, 0, 0, 1, st);
        @(posedge clk);
        @(posedge clk);
        chk("drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
